seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream display stage for the lab3 stopwatch. It takes four packed BCD digits plus blank/blink masks from the counter logic and time-multiplexes them onto the Basys3 four-digit common-anode seven-segment display.
- Runs on the board clock with internal refresh and blink dividers. Provides anti-ghost guard blanking and once-per-frame digit snapshotting so a value is never torn across a scan.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit is selected. Must satisfy SCAN_DIV >= GUARD+2.
- GUARD, 2000: cycles at the start of each digit slot with all anodes off (anti-ghost).
- BLINK_DIV, 33333333: clk cycles per blink half-period.

Ports:
- clk, input, 1: board clock.
- reset, input, 1: asynchronous, active-low reset.
- digits, input, 16: BCD digits. [3:0] is the rightmost digit (an[0]); [15:12] is the leftmost (an[3]).
- blank_mask, input, 4: bit i=1 keeps digit i dark.
- blink_mask, input, 4: bit i=1 makes digit i dark during the blink-off phase.
- blink_en, input, 1: enables blinking.
- seg, output, 7: active-low segments, {g,f,e,d,c,b,a}.
- an, output, 4: active-low anodes.
- frame_start, output, 1: one-cycle pulse when digit 0's slot begins.

Behaviour:
- Asynchronous reset (reset=0) applies immediately:
  - an=4'hF, seg=7'h7F, frame_start=0.
  - scan counter cnt=0, idx=0, blink counter bcnt=0, phase=0.
  - snapshot registers (digits, blank_mask, blink_mask) cleared to 0.
- Reset may assert mid-scan; outputs go dark asynchronously. The first lit digit after release is idx 0.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1. At cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0 (2-bit wrap).
  - On the cycle idx wraps 3→0, the snapshot loads digits, blank_mask and blink_mask. The display uses only snapshot values.
  - Reset-release frame: snapshot also loads on the first clk edge after reset deasserts.
- Blink:
  - blink_en=1: bcnt counts 0..BLINK_DIV-1; at terminal count it wraps and phase toggles. phase=1 means blink-off.
  - blink_en=0: bcnt and phase are forced to 0 on the next edge.
- Decode, 4-bit value to active-low seg:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Values 10–15 display a dash, 3F.
- Output register: seg, an and frame_start are registered and reflect cnt/idx/phase from the previous cycle (1-cycle latency).
  - If prev cnt < GUARD: an=F, seg=7F.
  - Else if snap_blank[idx] or (phase & snap_blink[idx]): an=F, seg=7F.
  - Else: an = ~(4'b0001<<idx), seg = decode(snap_digit[idx]).
- frame_start is 1 exactly one cycle after the edge where cnt==0 and idx==0 (i.e. registered from the cnt==0 && idx==0 state).
- Exactly zero or one anode is low at any time. An anode never goes low in the same cycle that seg changes to a different digit's pattern.
- Simultaneous events:
  - A blink toggle coinciding with a slot boundary is applied together with it.
  - Mask changes mid-frame take effect only at the next frame.

Test Plan (SCAN_DIV=8, GUARD=2, BLINK_DIV=64):
- Reset check: pulse reset low mid-slot with idx=2 → an=F and seg=7F in the same delta, no clk edge required. After release, frame_start pulses, then an=1110 first appears at cycle GUARD+1 after release.
- digits=16'h1234, masks=0, blink_en=0 → lit slots repeat in the sequence:
  - an=1110 with seg=19,
  - an=1101 with seg=30,
  - an=1011 with seg=24,
  - an=0111 with seg=79.
  - Each slot gives 6 lit cycles preceded by 2 dark cycles; the period is 32 cycles.
- Snapshot test: change digits from 1234 to 5678 while idx=1 → the remaining slots of the frame still show 2 and 1. The next frame shows 8 (seg=00) on an[0].
- digits=16'hFA09 → an[0] shows seg=10, an[1] seg=40, an[2] seg=3F, an[3] seg=3F.
- blink_mask=0001, blink_en=1:
  - an[0] goes low only during phase=0 windows, which alternate every 64 cycles. Other digits are unaffected.
  - Drop blink_en during phase=1 → an[0] lit again from the next frame's slot 0.
- blank_mask=1000 with digits=1234 → an[3] never goes low. The other three digits behave as in the 16'h1234 scenario. Verify on every cycle that at most one an bit is 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-seg scanner with guard blanking, blink and per-frame digit snapshot.
// Outputs are registered one cycle behind the scan state; no backpressure, inputs are sampled once per frame.
module seg7_scan_driver #(
   parameter int SCAN_DIV  = 100000,
   parameter int GUARD     = 2000,
   parameter int BLINK_DIV = 33333333
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  blank_mask,
   input  logic [3:0]  blink_mask,
   input  logic        blink_en,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GUARD_END = CW'(GUARD);
   localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          first_q;
   logic [15:0]   snap_dig_q, snap_dig_d;
   logic [3:0]    snap_blank_q, snap_blank_d;
   logic [3:0]    snap_blink_q, snap_blink_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          fs_q, fs_d;

   logic          slot_end;
   logic          snap_load;
   logic          dark;
   logic [3:0]    cur_digit;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
      idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

      // Snapshot only at frame boundaries (and right after reset) so a frame never mixes two values.
      snap_load    = first_q | (slot_end & (idx_q == 2'd3));
      snap_dig_d   = snap_load ? digits     : snap_dig_q;
      snap_blank_d = snap_load ? blank_mask : snap_blank_q;
      snap_blink_d = snap_load ? blink_mask : snap_blink_q;

      bcnt_d  = '0;
      phase_d = 1'b0;
      if (blink_en) begin
         if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d  = bcnt_q + BW'(1);
            phase_d = phase_q;
         end
      end

      cur_digit = snap_dig_q[{idx_q, 2'b00} +: 4];
      // Guard window keeps every anode off while the segment lines settle onto the new digit.
      dark  = (cnt_q < GUARD_END) | snap_blank_q[idx_q] | (phase_q & snap_blink_q[idx_q]);
      an_d  = dark ? 4'hF  : ~(4'b0001 << idx_q);
      seg_d = dark ? 7'h7F : decode(cur_digit);
      fs_d  = (cnt_q == '0) && (idx_q == 2'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         bcnt_q       <= '0;
         phase_q      <= 1'b0;
         first_q      <= 1'b1;
         snap_dig_q   <= 16'h0000;
         snap_blank_q <= 4'h0;
         snap_blink_q <= 4'h0;
         seg_q        <= 7'h7F;
         an_q         <= 4'hF;
         fs_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         bcnt_q       <= bcnt_d;
         phase_q      <= phase_d;
         first_q      <= 1'b0;
         snap_dig_q   <= snap_dig_d;
         snap_blank_q <= snap_blank_d;
         snap_blink_q <= snap_blink_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         fs_q         <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: time-based reference model checked every cycle, plus directed literal checks.
module tb_seg7_scan_driver;

   localparam int SD = 8;
   localparam int GD = 2;
   localparam int BD = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  blank_mask = 4'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic        blink_en = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_start;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .blink_en   (blink_en),
      .seg        (seg),
      .an         (an),
      .frame_start(frame_start)
   );

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   // Reference model: the display is a pure function of edges since reset release (e)
   // and of the length of the current run of enabled blink edges (n_en).
   int          e = 0;
   int          n_en = 0;
   int          mc, ms;
   bit          mph;
   bit          m_phase = 1'b0;
   logic [15:0] m_dig = 16'h0000;
   logic [3:0]  m_blank = 4'h0;
   logic [3:0]  m_blink = 4'h0;
   logic [3:0]  exp_an = 4'hF;
   logic [6:0]  exp_seg = 7'h7F;
   logic        exp_fs = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         e = 0; n_en = 0; m_phase = 1'b0;
         m_dig = 16'h0000; m_blank = 4'h0; m_blink = 4'h0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_fs = 1'b0;
      end else begin
         mc  = e % SD;
         ms  = (e / SD) % 4;
         mph = ((n_en / BD) % 2) == 1;
         if (mc < GD || m_blank[ms] || (mph && m_blink[ms])) begin
            exp_an = 4'hF; exp_seg = 7'h7F;
         end else begin
            exp_an  = ~(4'b0001 << ms);
            exp_seg = seg_tab[m_dig[4*ms +: 4]];
         end
         exp_fs = (mc == 0) && (ms == 0);
         if (e == 0 || (mc == SD-1 && ms == 3)) begin
            m_dig = digits; m_blank = blank_mask; m_blink = blink_mask;
         end
         n_en    = blink_en ? n_en + 1 : 0;
         m_phase = ((n_en / BD) % 2) == 1;
         e++;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
         errors++;
         $display("FAIL model_cmp t=%0t an=%b want %b seg=%h want %h fs=%b want %b",
                  $time, an, exp_an, seg, exp_seg, frame_start, exp_fs);
      end
      checks++;
      if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
         errors++;
         $display("FAIL one_anode t=%0t an=%b want at most one low bit", $time, an);
      end
   end

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
      end
   endtask

   task automatic wait_an(input logic [3:0] v, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (an == v) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_fs(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (frame_start) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   int         lit_cnt [4];
   logic [6:0] lit_seg [4];
   int         lit_bad;

   task automatic count_window(input int n);
      int j;
      for (int k = 0; k < 4; k++) begin
         lit_cnt[k] = 0; lit_seg[k] = 7'h7F;
      end
      lit_bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         case (an)
            4'hE:    j = 0;
            4'hD:    j = 1;
            4'hB:    j = 2;
            4'h7:    j = 3;
            default: j = -1;
         endcase
         if (j >= 0) begin
            if (lit_cnt[j] > 0 && seg != lit_seg[j]) lit_bad++;
            lit_seg[j] = seg;
            lit_cnt[j]++;
         end
      end
   endtask

   task automatic expect_digit(input string name, input logic [3:0] a, input logic [6:0] s);
      bit ok;
      wait_an(a, 100, ok);
      chk({name, "_found"}, ok, 1);
      chk({name, "_seg"}, seg, s);
   endtask

   task automatic settle_two_frames();
      bit ok;
      wait_fs(100, ok);
      chk("settle_fs1", ok, 1);
      wait_fs(100, ok);
      chk("settle_fs2", ok, 1);
   endtask

   initial begin
      int k;
      bit ok;

      repeat (3) @(negedge clk);
      chk("rst_an", an, 'hF);
      chk("rst_seg", seg, 'h7F);
      chk("rst_fs", frame_start, 0);

      // Release and time the first lit digit.
      digits = 16'h1234;
      @(negedge clk);
      reset = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 1) chk("fs_after_release", frame_start, 1);
         if (an == 4'b1110) begin
            k = i;
            break;
         end
      end
      chk("first_lit_cycle", k, GD+1);

      count_window(64);
      chk("p1234_an0_cnt", lit_cnt[0], 12);
      chk("p1234_an1_cnt", lit_cnt[1], 12);
      chk("p1234_an2_cnt", lit_cnt[2], 12);
      chk("p1234_an3_cnt", lit_cnt[3], 12);
      chk("p1234_an0_seg", lit_seg[0], 'h19);
      chk("p1234_an1_seg", lit_seg[1], 'h30);
      chk("p1234_an2_seg", lit_seg[2], 'h24);
      chk("p1234_an3_seg", lit_seg[3], 'h79);
      chk("p1234_stable", lit_bad, 0);

      // Asynchronous reset while digit 2 is lit.
      wait_an(4'b1011, 100, ok);
      chk("mid_rst_found", ok, 1);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("async_rst_an", an, 'hF);
      chk("async_rst_seg", seg, 'h7F);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Change digits mid-frame: remaining slots keep the old snapshot.
      wait_an(4'b1101, 100, ok);
      chk("snap_slot1_found", ok, 1);
      digits = 16'h5678;
      expect_digit("snap_old2", 4'b1011, 7'h24);
      expect_digit("snap_old1", 4'b0111, 7'h79);
      expect_digit("snap_new8", 4'b1110, 7'h00);

      // Out-of-range values show a dash.
      digits = 16'hFA09;
      wait_fs(100, ok);
      chk("fa09_fs", ok, 1);
      expect_digit("fa09_d0", 4'b1110, 7'h10);
      expect_digit("fa09_d1", 4'b1101, 7'h40);
      expect_digit("fa09_d2", 4'b1011, 7'h3F);
      expect_digit("fa09_d3", 4'b0111, 7'h3F);

      // Blink digit 0.
      digits = 16'h1234;
      blink_mask = 4'b0001;
      blink_en = 1'b1;
      settle_two_frames();
      count_window(256);
      chk("blink_an0_cnt", lit_cnt[0], 24);
      chk("blink_an1_cnt", lit_cnt[1], 48);
      chk("blink_an0_seg", lit_seg[0], 'h19);
      chk("blink_an3_seg", lit_seg[3], 'h79);

      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_phase) begin
            ok = 1'b1;
            break;
         end
      end
      chk("blink_phase1_reached", ok, 1);
      blink_en = 1'b0;
      expect_digit("blink_drop_an0", 4'b1110, 7'h19);

      // Blank the leftmost digit.
      blink_mask = 4'h0;
      blank_mask = 4'b1000;
      settle_two_frames();
      count_window(64);
      chk("blank_an3_cnt", lit_cnt[3], 0);
      chk("blank_an0_cnt", lit_cnt[0], 12);
      chk("blank_an1_cnt", lit_cnt[1], 12);
      chk("blank_an2_cnt", lit_cnt[2], 12);
      chk("blank_an0_seg", lit_seg[0], 'h19);
      chk("blank_an2_seg", lit_seg[2], 'h24);

      // Random traffic against the model.
      blank_mask = 4'h0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!reset) reset = 1'b1;
         if ($urandom_range(0, 39) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 59) == 0) blank_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 59) == 0) blink_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
         if ($urandom_range(0, 999) == 0) reset = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
